frogger_game_sequencer: RTL

//  Game-level sequencer for the Frogger datapath: owns the traffic-shift timebase, lives, level and win/lose state.

---
 rtl/frogger_pkg.sv | 18 +
 rtl/frogger_game_sequencer_if.sv | 28 ++
 rtl/frogger_tick_prescaler.sv | 27 ++
 rtl/frogger_game_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared types and widths for the Frogger game sequencer slice.
package frogger_pkg;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PLAY,
    HIT,
    RESPAWN,
    LEVELUP,
    GAMEOVER,
    WIN
  } state_t;

endpackage

// File: rtl/frogger_game_sequencer_if.sv
// Control/status bundle between the game sequencer and the matrix datapath.
interface frogger_game_sequencer_if;
  import frogger_pkg::*;

  logic               startGame_InLow;
  logic               collision_InHigh;
  logic               goal_InHigh;
  logic               traffic_shift_OutHigh;
  logic               point_clear_OutLow;
  logic               move_enable_OutHigh;
  logic [LIVES_W-1:0] lives_Out;
  logic [LEVEL_W-1:0] level_Out;
  logic               gameover_OutHigh;
  logic               win_OutHigh;

  modport master (
    output startGame_InLow, collision_InHigh, goal_InHigh,
    input  traffic_shift_OutHigh, point_clear_OutLow, move_enable_OutHigh,
           lives_Out, level_Out, gameover_OutHigh, win_OutHigh
  );

  modport slave (
    input  startGame_InLow, collision_InHigh, goal_InHigh,
    output traffic_shift_OutHigh, point_clear_OutLow, move_enable_OutHigh,
           lives_Out, level_Out, gameover_OutHigh, win_OutHigh
  );

endinterface

// File: rtl/frogger_tick_prescaler.sv
// Programmable-period counter; tick marks the last count of each period.
module frogger_tick_prescaler #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count_q;

  assign tick = enable && (count_q == period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frogger_game_sequencer.sv
// Game-level sequencer: traffic timebase, lives, level and win/lose state.
// All outputs are registers; the shared prescaler times both traffic and the hit freeze.
module frogger_game_sequencer
  import frogger_pkg::*;
#(
  parameter int TICK_BASE  = 25_000_000,
  parameter int TICK_STEP  = 2_500_000,
  parameter int HIT_HOLD   = 50_000_000,
  parameter int LIVES_INIT = 3,
  parameter int LEVEL_MAX  = 7,
  parameter int CNT_W      = 26
) (
  input  logic                     SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                     SC_STATEMACHINEPOINT_RESET_InHigh,
  frogger_game_sequencer_if.slave  bus
);

  localparam logic [CNT_W+2:0]   BASE_X     = (CNT_W+3)'(TICK_BASE);
  localparam logic [CNT_W+2:0]   STEP_X     = (CNT_W+3)'(TICK_STEP);
  localparam logic [CNT_W-1:0]   HOLD_P     = CNT_W'(HIT_HOLD);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(LEVEL_MAX);

  state_t             state_q;
  logic [LIVES_W-1:0] lives_q;
  logic [LEVEL_W-1:0] level_q;
  logic               shift_q;
  logic               pointClear_q;
  logic               moveEnable_q;
  logic               gameover_q;
  logic               win_q;

  logic [CNT_W+2:0] stepProd;
  logic [CNT_W+2:0] periodDiff;
  logic [CNT_W-1:0] playPeriod;
  logic [CNT_W-1:0] tickPeriod;
  logic             tickEnable;
  logic             tickClear;
  logic             tick;

  // Faster traffic per level, floored at one step so the period never collapses.
  always_comb begin
    stepProd   = STEP_X * {{CNT_W{1'b0}}, level_q};
    periodDiff = BASE_X - stepProd;
    if ((stepProd > BASE_X) || (periodDiff < STEP_X)) begin
      playPeriod = STEP_X[CNT_W-1:0];
    end else begin
      playPeriod = periodDiff[CNT_W-1:0];
    end
  end

  // Clearing on the collision cycle makes the hit hold start from zero.
  assign tickPeriod = (state_q == HIT) ? HOLD_P : playPeriod;
  assign tickEnable = (state_q == PLAY) || (state_q == HIT);
  assign tickClear  = !tickEnable || ((state_q == PLAY) && bus.collision_InHigh);

  frogger_tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk    (SC_STATEMACHINEPOINT_CLOCK_50),
    .rst    (SC_STATEMACHINEPOINT_RESET_InHigh),
    .clear  (tickClear),
    .enable (tickEnable),
    .period (tickPeriod),
    .tick   (tick)
  );

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      state_q      <= IDLE;
      lives_q      <= '0;
      level_q      <= '0;
      shift_q      <= 1'b0;
      pointClear_q <= 1'b1;
      moveEnable_q <= 1'b0;
      gameover_q   <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      shift_q      <= 1'b0;
      pointClear_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!bus.startGame_InLow) begin
            state_q      <= START;
            pointClear_q <= 1'b0;
          end
        end
        START: begin
          lives_q      <= LIVES_LOAD;
          level_q      <= '0;
          moveEnable_q <= 1'b1;
          state_q      <= PLAY;
        end
        PLAY: begin
          shift_q <= tick && !bus.collision_InHigh;
          if (bus.collision_InHigh) begin
            state_q      <= HIT;
            moveEnable_q <= 1'b0;
            if (lives_q != '0) lives_q <= lives_q - LIVES_W'(1);
          end else if (bus.goal_InHigh) begin
            state_q      <= LEVELUP;
            moveEnable_q <= 1'b0;
            if (level_q != LEVEL_TOP) pointClear_q <= 1'b0;
          end
        end
        HIT: begin
          if (tick) begin
            if (lives_q == '0) begin
              state_q    <= GAMEOVER;
              gameover_q <= 1'b1;
            end else begin
              state_q      <= RESPAWN;
              pointClear_q <= 1'b0;
            end
          end
        end
        RESPAWN: begin
          state_q      <= PLAY;
          moveEnable_q <= 1'b1;
        end
        LEVELUP: begin
          if (level_q == LEVEL_TOP) begin
            state_q <= WIN;
            win_q   <= 1'b1;
          end else begin
            level_q      <= level_q + LEVEL_W'(1);
            state_q      <= PLAY;
            moveEnable_q <= 1'b1;
          end
        end
        GAMEOVER, WIN: begin
          if (!bus.startGame_InLow) begin
            state_q      <= START;
            pointClear_q <= 1'b0;
            gameover_q   <= 1'b0;
            win_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.traffic_shift_OutHigh = shift_q;
  assign bus.point_clear_OutLow    = pointClear_q;
  assign bus.move_enable_OutHigh   = moveEnable_q;
  assign bus.lives_Out             = lives_q;
  assign bus.level_Out             = level_q;
  assign bus.gameover_OutHigh      = gameover_q;
  assign bus.win_OutHigh           = win_q;

endmodule
